// File: rtl/anti_theft_pkg.sv
// Shared definitions for the anti-theft controller.
//
// Holds the controller state encoding and the default timing constants so
// the top level and the timer sub-module agree on them.
//
// Contents:
//   T_*_DEF    default tick counts for arming, grace periods and siren hold
//   CNT_W_DEF  default timer counter width
//   state_e    controller state encoding
//   is_armed() true in any state where the system counts as armed
package anti_theft_pkg;

  localparam int T_ARM_DEF       = 6;
  localparam int T_DRIVER_DEF    = 8;
  localparam int T_PASSENGER_DEF = 15;
  localparam int T_ALARM_DEF     = 10;
  localparam int CNT_W_DEF       = 5;

  // Codes 6 and 7 are unused and treated as illegal by the controller.
  typedef enum logic [2:0] {
    ST_DISARMED   = 3'd0,
    ST_WAIT_CLOSE = 3'd1,
    ST_ARMING     = 3'd2,
    ST_ARMED      = 3'd3,
    ST_TRIGGERED  = 3'd4,
    ST_ALARM      = 3'd5
  } state_e;

  function automatic logic is_armed(input state_e s);
    return (s == ST_ARMED) || (s == ST_TRIGGERED) || (s == ST_ALARM);
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// Load/decrement/expire tick counter used by the anti-theft controller.
//
// A load takes priority over everything, so a tick arriving in the same
// cycle as the load is ignored. After a load of N the counter expires on
// the Nth following tick. The count saturates at zero.
//
// Ports:
//   clock     system clock
//   reset     asynchronous active-high reset, clears the count
//   load      load load_val this cycle
//   load_val  value to load (CNT_W bits, unsigned)
//   tick      one-cycle time-base pulse
//   expired   combinational, high on the cycle where count is 1 and tick is 1
module alarm_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load wins, otherwise count down on tick without going below 0.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is left ungated by load: the controller decides whether a
  // concurrent reload overrides it, which avoids a combinational loop.
  assign expired = tick && (count_q == CNT_W'(1));

endmodule

// File: rtl/anti_theft_controller.sv
// Vehicle anti-theft controller.
//
// Arms itself a fixed number of ticks after the driver leaves and shuts the
// door, raises the alarm if a door is opened and not answered by the
// ignition within a grace period, and holds the siren until the doors have
// been closed for a while. Ignition always disarms.
//
// Ports:
//   clock        system clock
//   reset        asynchronous active-high reset
//   tick         one-cycle 1 Hz time-base pulse
//   ignition     key on
//   door_driver  driver door open
//   door_pass    passenger door open
//   siren        alarm siren drive
//   status_led   blinks in ARMED, solid in TRIGGERED/ALARM
//   armed        high in ARMED, TRIGGERED and ALARM
//   fuel_en      fuel pump permission, high only in DISARMED
module anti_theft_controller
  import anti_theft_pkg::*;
#(
  parameter int T_ARM       = T_ARM_DEF,
  parameter int T_DRIVER    = T_DRIVER_DEF,
  parameter int T_PASSENGER = T_PASSENGER_DEF,
  parameter int T_ALARM     = T_ALARM_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic ignition,
  input  logic door_driver,
  input  logic door_pass,
  output logic siren,
  output logic status_led,
  output logic armed,
  output logic fuel_en
);

  state_e           state_q;
  state_e           state_d;
  logic             blink_q;
  logic             blink_d;
  logic             siren_q;
  logic             siren_d;
  logic             led_q;
  logic             led_d;
  logic             armed_q;
  logic             armed_d;
  logic             fuel_en_q;
  logic             fuel_en_d;

  logic             timer_load;
  logic [CNT_W-1:0] timer_load_val;
  logic             timer_expired;
  logic             any_door;

  assign any_door = door_driver || door_pass;

  alarm_timer #(
    .CNT_W(CNT_W)
  ) u_alarm_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (timer_load),
    .load_val(timer_load_val),
    .tick    (timer_tick_unused_guard(tick)),
    .expired (timer_expired)
  );

  function automatic logic timer_tick_unused_guard(input logic t);
    return t;
  endfunction

  // Next-state logic. Every transition into a timed state loads the timer
  // on the same cycle, so the new state starts with a full count.
  always_comb begin
    state_d        = state_q;
    timer_load     = 1'b0;
    timer_load_val = '0;
    if (ignition) begin
      state_d = ST_DISARMED;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          if (door_driver) state_d = ST_WAIT_CLOSE;
        end
        ST_WAIT_CLOSE: begin
          if (!door_driver) begin
            state_d        = ST_ARMING;
            timer_load     = 1'b1;
            timer_load_val = CNT_W'(T_ARM);
          end
        end
        ST_ARMING: begin
          if (any_door) begin
            state_d = ST_WAIT_CLOSE;
          end else if (timer_expired) begin
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          // The driver door gets the shorter grace period when both open.
          if (door_driver) begin
            state_d        = ST_TRIGGERED;
            timer_load     = 1'b1;
            timer_load_val = CNT_W'(T_DRIVER);
          end else if (door_pass) begin
            state_d        = ST_TRIGGERED;
            timer_load     = 1'b1;
            timer_load_val = CNT_W'(T_PASSENGER);
          end
        end
        ST_TRIGGERED: begin
          if (timer_expired) begin
            state_d        = ST_ALARM;
            timer_load     = 1'b1;
            timer_load_val = CNT_W'(T_ALARM);
          end
        end
        ST_ALARM: begin
          // An open door keeps restarting the hold time, so expiry only
          // counts once every door has stayed shut for the full period.
          if (any_door) begin
            timer_load     = 1'b1;
            timer_load_val = CNT_W'(T_ALARM);
          end else if (timer_expired) begin
            state_d = ST_ARMED;
          end
        end
        default: begin
          state_d = ST_DISARMED;
        end
      endcase
    end
  end

  // Output decode from the next state so the registered outputs line up
  // with the registered state. The blink bit starts at 0 on entry to ARMED
  // and flips on each tick spent in ARMED.
  always_comb begin
    blink_d   = (state_d == ST_ARMED) &&
                (blink_q ^ (tick && (state_q == ST_ARMED)));
    siren_d   = (state_d == ST_ALARM);
    led_d     = (state_d == ST_ARMED) ? blink_d :
                ((state_d == ST_TRIGGERED) || (state_d == ST_ALARM));
    armed_d   = is_armed(state_d);
    fuel_en_d = (state_d == ST_DISARMED);
  end

  // State and registered outputs; reset puts the outputs straight into
  // their DISARMED values so the siren drops immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_DISARMED;
      blink_q   <= 1'b0;
      siren_q   <= 1'b0;
      led_q     <= 1'b0;
      armed_q   <= 1'b0;
      fuel_en_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      blink_q   <= blink_d;
      siren_q   <= siren_d;
      led_q     <= led_d;
      armed_q   <= armed_d;
      fuel_en_q <= fuel_en_d;
    end
  end

  assign siren      = siren_q;
  assign status_led = led_q;
  assign armed      = armed_q;
  assign fuel_en    = fuel_en_q;

endmodule

// File: tb/tb_anti_theft_controller.sv
// Self-checking bench for anti_theft_controller.
//
// A behavioural model tracks the car's mode, the number of ticks left in the
// current wait and how many ticks have been spent armed; every cycle the DUT
// outputs are compared with what the model predicts. Directed sequences
// cover the named scenarios, then biased random stimulus runs.
module tb_anti_theft_controller;

  localparam int T_ARM       = 6;
  localparam int T_DRIVER    = 8;
  localparam int T_PASSENGER = 15;
  localparam int T_ALARM     = 10;

  localparam int MD_DISARMED = 0;
  localparam int MD_WAIT     = 1;
  localparam int MD_ARMING   = 2;
  localparam int MD_ARMED    = 3;
  localparam int MD_TRIG     = 4;
  localparam int MD_ALARM    = 5;

  logic clock;
  logic reset;
  logic tick;
  logic ignition;
  logic door_driver;
  logic door_pass;
  logic siren;
  logic status_led;
  logic armed;
  logic fuel_en;

  int check_count = 0;
  int fail_count  = 0;

  int m_mode;
  int m_left;
  int m_armed_ticks;

  anti_theft_controller dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .ignition   (ignition),
    .door_driver(door_driver),
    .door_pass  (door_pass),
    .siren      (siren),
    .status_led (status_led),
    .armed      (armed),
    .fuel_en    (fuel_en)
  );

  // 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0b, expected %0b at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_mode        = MD_DISARMED;
    m_left        = 0;
    m_armed_ticks = 0;
  endtask

  // One clock of the reference behaviour. The wait expires on the tick that
  // uses up its last remaining tick; a reload swallows a simultaneous tick.
  task automatic modelStep(input logic t, input logic ign, input logic dd, input logic dp);
    bit done;
    int next_mode;
    int reload;
    done      = t && (m_left == 1);
    next_mode = m_mode;
    reload    = -1;
    if (ign) begin
      next_mode = MD_DISARMED;
    end else if (m_mode == MD_DISARMED) begin
      if (dd) next_mode = MD_WAIT;
    end else if (m_mode == MD_WAIT) begin
      if (!dd) begin next_mode = MD_ARMING; reload = T_ARM; end
    end else if (m_mode == MD_ARMING) begin
      if (dd || dp) next_mode = MD_WAIT;
      else if (done) next_mode = MD_ARMED;
    end else if (m_mode == MD_ARMED) begin
      if (dd) begin next_mode = MD_TRIG; reload = T_DRIVER; end
      else if (dp) begin next_mode = MD_TRIG; reload = T_PASSENGER; end
    end else if (m_mode == MD_TRIG) begin
      if (done) begin next_mode = MD_ALARM; reload = T_ALARM; end
    end else if (m_mode == MD_ALARM) begin
      if (dd || dp) reload = T_ALARM;
      else if (done) next_mode = MD_ARMED;
    end
    if (reload >= 0) m_left = reload;
    else if (t && m_left > 0) m_left = m_left - 1;
    if (next_mode == MD_ARMED && m_mode == MD_ARMED) begin
      if (t) m_armed_ticks++;
    end else begin
      m_armed_ticks = 0;
    end
    m_mode = next_mode;
  endtask

  function automatic logic expSiren();
    return m_mode == MD_ALARM;
  endfunction

  function automatic logic expArmed();
    return m_mode == MD_ARMED || m_mode == MD_TRIG || m_mode == MD_ALARM;
  endfunction

  function automatic logic expFuel();
    return m_mode == MD_DISARMED;
  endfunction

  function automatic logic expLed();
    if (m_mode == MD_ARMED) return (m_armed_ticks % 2) == 1;
    return m_mode == MD_TRIG || m_mode == MD_ALARM;
  endfunction

  // Drive one cycle of inputs, advance the model at the edge and compare
  // all outputs shortly after it.
  task automatic applyStimulus(input logic t, input logic ign, input logic dd, input logic dp);
    tick        = t;
    ignition    = ign;
    door_driver = dd;
    door_pass   = dp;
    @(posedge clock);
    modelStep(t, ign, dd, dp);
    #1;
    checkOutput("siren", siren, expSiren());
    checkOutput("status_led", status_led, expLed());
    checkOutput("armed", armed, expArmed());
    checkOutput("fuel_en", fuel_en, expFuel());
  endtask

  // n ticks, each preceded by an idle cycle, with the given door levels.
  task automatic runTicks(input int n, input logic dd, input logic dp);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, dd, dp);
      applyStimulus(1'b1, 1'b0, dd, dp);
    end
  endtask

  task automatic armFromDisarmed();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(T_ARM, 1'b0, 1'b0);
  endtask

  initial begin
    int door_pct;
    reset       = 1'b1;
    tick        = 1'b0;
    ignition    = 1'b0;
    door_driver = 1'b0;
    door_pass   = 1'b0;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_siren", siren, 1'b0);
    checkOutput("reset_led", status_led, 1'b0);
    checkOutput("reset_armed", armed, 1'b0);
    checkOutput("reset_fuel_en", fuel_en, 1'b1);
    reset = 1'b0;

    // Driver leaves: open, close, then T_ARM ticks to arm.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(5, 1'b0, 1'b0);
    checkOutput("arm_5_armed", armed, 1'b0);
    runTicks(1, 1'b0, 1'b0);
    checkOutput("arm_6_armed", armed, 1'b1);
    checkOutput("arm_6_fuel_en", fuel_en, 1'b0);

    // LED blink in ARMED.
    checkOutput("blink_0", status_led, 1'b0);
    runTicks(1, 1'b0, 1'b0);
    checkOutput("blink_1", status_led, 1'b1);
    runTicks(1, 1'b0, 1'b0);
    checkOutput("blink_2", status_led, 1'b0);

    // Ignition disarms from ARMED.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ign_fuel_en", fuel_en, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Door opened while arming restarts the arming wait.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(3, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rearm_wait_armed", armed, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(5, 1'b0, 1'b0);
    checkOutput("rearm_5_armed", armed, 1'b0);
    runTicks(1, 1'b0, 1'b0);
    checkOutput("rearm_6_armed", armed, 1'b1);

    // Passenger trigger with a tick on the trigger cycle (must be ignored).
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("pass_trig_led", status_led, 1'b1);
    runTicks(14, 1'b0, 1'b0);
    checkOutput("pass_14_siren", siren, 1'b0);
    runTicks(1, 1'b0, 1'b0);
    checkOutput("pass_15_siren", siren, 1'b1);
    runTicks(9, 1'b0, 1'b0);
    checkOutput("hold_9_siren", siren, 1'b1);
    runTicks(1, 1'b0, 1'b0);
    checkOutput("hold_10_siren", siren, 1'b0);
    checkOutput("hold_10_armed", armed, 1'b1);

    // Both doors: driver grace period applies.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    runTicks(7, 1'b0, 1'b0);
    checkOutput("both_7_siren", siren, 1'b0);
    runTicks(1, 1'b0, 1'b0);
    checkOutput("both_8_siren", siren, 1'b1);

    // Door held open in ALARM keeps the siren on; then T_ALARM ticks after close.
    runTicks(20, 1'b0, 1'b1);
    checkOutput("held_siren", siren, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(9, 1'b0, 1'b0);
    checkOutput("close_9_siren", siren, 1'b1);
    runTicks(1, 1'b0, 1'b0);
    checkOutput("close_10_siren", siren, 1'b0);
    checkOutput("close_10_armed", armed, 1'b1);

    // Ignition during TRIGGERED at the 5th tick.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    runTicks(4, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("trig_ign_siren", siren, 1'b0);
    checkOutput("trig_ign_fuel_en", fuel_en, 1'b1);
    checkOutput("trig_ign_armed", armed, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset asserted mid-ALARM silences the siren before any clock edge.
    armFromDisarmed();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    runTicks(T_PASSENGER, 1'b0, 1'b0);
    checkOutput("pre_reset_siren", siren, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_siren", siren, 1'b0);
    checkOutput("async_reset_led", status_led, 1'b0);
    checkOutput("async_reset_armed", armed, 1'b0);
    checkOutput("async_reset_fuel_en", fuel_en, 1'b1);
    @(posedge clock);
    #1;
    checkOutput("held_reset_siren", siren, 1'b0);
    reset = 1'b0;
    modelReset();

    // Biased random traffic: door activity level changes per segment so
    // the system both arms and gets triggered.
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(0, 3))
        0:       door_pct = 1;
        1:       door_pct = 4;
        2:       door_pct = 20;
        default: door_pct = 50;
      endcase
      for (int c = 0; c < 75; c++) begin
        applyStimulus(1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 99) < 2),
                      1'($urandom_range(0, 99) < door_pct),
                      1'($urandom_range(0, 99) < door_pct));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
